// File: rtl/board_pkg.sv
// Shared types and constants for the playfield renderer: cell colours, the RGB
// palette and the scheduler state encoding.
package board_pkg;

  localparam int CELL_SHIFT = 4;
  localparam int RAM_DEPTH  = 200;

  typedef enum logic [2:0] {EMPTY, I, O, T, S, Z, J, L} cell_color_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t PALETTE [8] = '{
    '{8'h20, 8'h20, 8'h20},
    '{8'h00, 8'hFF, 8'hFF},
    '{8'hFF, 8'hFF, 8'h00},
    '{8'hA0, 8'h00, 8'hF0},
    '{8'h00, 8'hFF, 8'h00},
    '{8'hFF, 8'h00, 8'h00},
    '{8'h00, 8'h00, 8'hFF},
    '{8'hFF, 8'hA5, 8'h00}
  };

  localparam rgb_t BORDER_RGB = '{8'h00, 8'h00, 8'h40};

  typedef enum logic {IDLE, CLEAR} state_t;

endpackage

// File: rtl/board_ram.sv
// Single-port playfield cell store with a registered read port (one cycle of
// latency); addresses beyond the array read back as zero and never write.
module board_ram
  import board_pkg::*;
#(
  parameter int DEPTH = RAM_DEPTH
) (
  input  logic       clk_i,
  input  logic       we_i,
  input  logic [7:0] addr_i,
  input  logic [2:0] wdata_i,
  output logic [2:0] rdata_o
);

  logic [2:0] mem_q [DEPTH];
  logic [2:0] rdata_q;
  logic       addrOk;

  assign addrOk  = int'(addr_i) < DEPTH;
  assign rdata_o = rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i && addrOk) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= addrOk ? mem_q[addr_i] : 3'd0;
  end

endmodule

// File: rtl/board_render_scheduler.sv
// Shares the playfield RAM between the beam prefetch (absolute priority) and
// game-logic requests, maps cells to RGB and runs the clear sweep.
module board_render_scheduler
  import board_pkg::*;
#(
  parameter int FIELD_X0 = 160,
  parameter int FIELD_Y0 = 80,
  parameter int COLS     = 10,
  parameter int ROWS     = 20
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [9:0] x_i,
  input  logic [8:0] y_i,
  input  logic       xy_v_i,
  output logic [7:0] r_o,
  output logic [7:0] g_o,
  output logic [7:0] b_o,
  input  logic       req_v_i,
  input  logic       req_we_i,
  input  logic [4:0] req_row_i,
  input  logic [3:0] req_col_i,
  input  logic [2:0] req_data_i,
  output logic       req_ready_o,
  output logic       resp_v_o,
  output logic [2:0] resp_data_o,
  input  logic       clear_i,
  output logic       busy_o,
  output logic       clear_done_o
);

  localparam int FIELD_W = COLS << CELL_SHIFT;
  localparam int FIELD_H = ROWS << CELL_SHIFT;
  localparam int SLOT_X0 = FIELD_X0 - 2;
  localparam logic [7:0] LAST_ADDR = 8'(COLS * ROWS - 1);

  state_t      state_q;
  logic [7:0]  clearAddr_q;
  logic        respV_q;
  logic        rdOor_q;
  logic [2:0]  respHold_q;
  logic        slotDly_q;
  logic        clearDone_q;
  cell_color_t curCell_q;

  logic       inFieldX, inFieldY, vgaSlot, reqInRange, accept;
  logic [9:0] slotOff;
  logic [4:0] beamRow;
  logic [3:0] beamCol;
  logic [7:0] reqAddr, vgaAddr, ramAddr;
  logic       ramWe;
  logic [2:0] ramWdata, ramRdata;
  rgb_t       pix;

  // A fetch slot sits two pixels ahead of each cell so the RAM output can be
  // registered before the cell's first pixel is drawn.
  always_comb begin
    inFieldY   = (int'(y_i) >= FIELD_Y0) && (int'(y_i) < FIELD_Y0 + FIELD_H);
    inFieldX   = (int'(x_i) >= FIELD_X0) && (int'(x_i) < FIELD_X0 + FIELD_W);
    slotOff    = x_i - 10'(SLOT_X0);
    vgaSlot    = xy_v_i && inFieldY && (int'(x_i) >= SLOT_X0) &&
                 (slotOff[CELL_SHIFT-1:0] == '0) &&
                 (int'(slotOff >> CELL_SHIFT) < COLS);
    beamRow    = 5'((int'(y_i) - FIELD_Y0) >> CELL_SHIFT);
    beamCol    = 4'(slotOff >> CELL_SHIFT);
    vgaAddr    = 8'(int'(beamRow) * COLS + int'(beamCol));
    reqInRange = (int'(req_row_i) < ROWS) && (int'(req_col_i) < COLS);
    reqAddr    = 8'(int'(req_row_i) * COLS + int'(req_col_i));
    req_ready_o = (state_q == IDLE) && !vgaSlot;
    accept      = req_v_i && req_ready_o;
    busy_o      = (state_q == CLEAR);
  end

  always_comb begin
    ramAddr  = reqAddr;
    ramWe    = 1'b0;
    ramWdata = req_data_i;
    if (vgaSlot) begin
      ramAddr = vgaAddr;
    end else if (state_q == CLEAR) begin
      ramAddr  = clearAddr_q;
      ramWe    = reset_i;
      ramWdata = 3'd0;
    end else if (accept && req_we_i && reqInRange) begin
      ramWe = reset_i;
    end
  end

  board_ram #(.DEPTH(RAM_DEPTH)) uRam (
    .clk_i  (clk_i),
    .we_i   (ramWe),
    .addr_i (ramAddr),
    .wdata_i(ramWdata),
    .rdata_o(ramRdata)
  );

  // Read data is only valid in the cycle after acceptance, so the visible
  // value is taken from the RAM then and held afterwards.
  always_comb begin
    resp_v_o     = respV_q;
    clear_done_o = clearDone_q;
    resp_data_o  = respHold_q;
    if (respV_q) begin
      resp_data_o = rdOor_q ? 3'd0 : ramRdata;
    end
    pix = '0;
    if (xy_v_i) begin
      pix = (inFieldX && inFieldY) ? PALETTE[curCell_q] : BORDER_RGB;
    end
    r_o = pix.r;
    g_o = pix.g;
    b_o = pix.b;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q     <= CLEAR;
      clearAddr_q <= '0;
      clearDone_q <= 1'b0;
      respV_q     <= 1'b0;
      rdOor_q     <= 1'b0;
      respHold_q  <= '0;
      slotDly_q   <= 1'b0;
      curCell_q   <= EMPTY;
    end else begin
      clearDone_q <= 1'b0;
      respV_q     <= accept && !req_we_i;
      if (accept && !req_we_i) begin
        rdOor_q <= !reqInRange;
      end
      if (respV_q) begin
        respHold_q <= resp_data_o;
      end
      slotDly_q <= vgaSlot;
      if (slotDly_q) begin
        curCell_q <= cell_color_t'(ramRdata);
      end
      case (state_q)
        IDLE: begin
          if (clear_i) begin
            state_q <= CLEAR;
          end
        end
        CLEAR: begin
          if (!vgaSlot) begin
            if (clearAddr_q == LAST_ADDR) begin
              state_q     <= IDLE;
              clearAddr_q <= '0;
              clearDone_q <= 1'b1;
            end else begin
              clearAddr_q <= clearAddr_q + 8'd1;
            end
          end
        end
      endcase
    end
  end

endmodule
